// File: rtl/rsa_decrypt_core.sv
// rsa_decrypt_core: toy-RSA decryption, m = c^d mod n, via left-to-right
// square-and-multiply over a bit-serial interleaved modular multiplier.
`default_nettype none

module rsa_decrypt_core #(
  parameter int KW        = 13,
  parameter int N_DEFAULT = 3233,
  parameter int D_DEFAULT = 2753
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [KW-1:0] data,
  input  logic          load_d,
  input  logic          load_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   output_data
);

  localparam int IW = $clog2(KW);
  localparam logic [IW-1:0] TOP_IDX = IW'(KW - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SQR  = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]    r_state;
  logic [KW-1:0] r_n;
  logic [KW-1:0] r_d;
  logic [KW-1:0] r_base;
  logic [KW-1:0] r_res;
  logic [KW:0]   r_acc;
  logic [IW-1:0] r_i;
  logic [IW-1:0] r_j;

  logic [KW-1:0] w_a;
  logic [KW-1:0] w_b;
  logic [KW:0]   w_n_ext;
  logic [KW:0]   w_dbl;
  logic [KW:0]   w_red1;
  logic [KW:0]   w_sum;
  logic [KW:0]   w_red2;
  logic          w_start_ok;

  // One interleaved step: acc = 2*acc mod n, then acc = (acc + b[j]*a) mod n.
  // acc and a are both below n, so KW+1 bits never overflow.
  always_comb begin
    w_a     = r_res;
    w_b     = (r_state == S_MUL) ? r_base : r_res;
    w_n_ext = {1'b0, r_n};
    w_dbl   = {r_acc[KW-1:0], 1'b0};
    w_red1  = (w_dbl >= w_n_ext) ? (w_dbl - w_n_ext) : w_dbl;
    w_sum   = w_red1 + (w_b[r_j] ? {1'b0, w_a} : {(KW+1){1'b0}});
    w_red2  = (w_sum >= w_n_ext) ? (w_sum - w_n_ext) : w_sum;
  end

  // Key values here are the pre-load ones, so a same-edge load cannot affect the check.
  assign w_start_ok = (data < r_n) && (r_n >= KW'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_n         <= KW'(N_DEFAULT);
      r_d         <= KW'(D_DEFAULT);
      r_base      <= '0;
      r_res       <= '0;
      r_acc       <= '0;
      r_i         <= '0;
      r_j         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      output_data <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_d) r_d <= data;
          if (load_n) r_n <= data;
          // Holding off during the done cycle keeps done from pulsing back-to-back.
          if (start && !done) begin
            if (w_start_ok) begin
              r_base  <= data;
              r_res   <= KW'(1);
              r_acc   <= '0;
              r_i     <= TOP_IDX;
              r_j     <= TOP_IDX;
              busy    <= 1'b1;
              err     <= 1'b0;
              r_state <= S_SQR;
            end else begin
              err         <= 1'b1;
              done        <= 1'b1;
              output_data <= '0;
            end
          end
        end
        S_SQR, S_MUL: begin
          if (r_j != '0) begin
            r_acc <= w_red2;
            r_j   <= r_j - 1'b1;
          end else begin
            r_res <= w_red2[KW-1:0];
            r_acc <= '0;
            r_j   <= TOP_IDX;
            if ((r_state == S_SQR) && r_d[r_i]) begin
              r_state <= S_MUL;
            end else if (r_i == '0) begin
              r_state <= S_FIN;
            end else begin
              r_i     <= r_i - 1'b1;
              r_state <= S_SQR;
            end
          end
        end
        S_FIN: begin
          output_data <= {{(16-KW){1'b0}}, r_res};
          done        <= 1'b1;
          busy        <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rsa_decrypt_core.sv
// Directed bench for rsa_decrypt_core with hand-computed RSA vectors.
`default_nettype none

module tb_rsa_decrypt_core;

  logic        clk;
  logic        rst_n;
  logic [12:0] data;
  logic        load_d;
  logic        load_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] output_data;

  int errors = 0;
  int checks = 0;

  logic [15:0] o;
  int          lat;
  int          bcnt;

  rsa_decrypt_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data        (data),
    .load_d      (load_d),
    .load_n      (load_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .output_data (output_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [12:0] val, input bit is_n);
    data = val;
    if (is_n) load_n = 1'b1; else load_d = 1'b1;
    tick();
    load_n = 1'b0;
    load_d = 1'b0;
    data   = '0;
  endtask

  // Cycle 0 is the cycle start is high; lat is the cycle done is first seen (-1 if never).
  // inj_kind 1: assert load_n(143)+start at inj_cyc; 2: assert reset at inj_cyc.
  task automatic run(input logic [12:0] val, input int inj_cyc, input int inj_kind,
                     output logic [15:0] res, output int latency, output int busy_cycles);
    latency     = -1;
    busy_cycles = 0;
    data  = val;
    start = 1'b1;
    tick();
    start = 1'b0;
    data  = '0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      if (done) begin
        latency = cyc;
        break;
      end
      if (busy) busy_cycles++;
      if (cyc == inj_cyc && inj_kind == 1) begin
        data   = 13'd143;
        load_n = 1'b1;
        start  = 1'b1;
      end
      if (cyc == inj_cyc && inj_kind == 2) begin
        rst_n = 1'b0;
        #1;
        break;
      end
      tick();
      load_n = 1'b0;
      start  = 1'b0;
      data   = '0;
    end
    res = output_data;
    if (latency > 0) tick();
  endtask

  initial begin
    rst_n = 1'b0; data = '0; load_d = 1'b0; load_n = 1'b0; start = 1'b0;
    repeat (3) tick();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_err",  32'(err), 0);
    chk("reset_out",  32'(output_data), 0);
    rst_n = 1'b1;
    tick();

    run(13'd2790, 0, 0, o, lat, bcnt);
    chk("c2790_out", 32'(o), 65);
    chk("c2790_lat", 32'(lat), 236);
    chk("c2790_busy_cycles", 32'(bcnt), 235);
    chk("c2790_err", 32'(err), 0);
    chk("done_one_cycle", 32'(done), 0);

    run(13'd0, 0, 0, o, lat, bcnt);
    chk("c0_out", 32'(o), 0);
    chk("c0_lat", 32'(lat), 236);
    run(13'd1, 0, 0, o, lat, bcnt);
    chk("c1_out", 32'(o), 1);
    chk("c1_lat", 32'(lat), 236);

    load(13'd1, 1'b0);
    run(13'd300, 0, 0, o, lat, bcnt);
    chk("d1_out", 32'(o), 300);
    chk("d1_lat", 32'(lat), 184);
    load(13'd2753, 1'b0);

    run(13'd3233, 0, 0, o, lat, bcnt);
    chk("rej_n_err", 32'(err), 1);
    chk("rej_n_lat", 32'(lat), 1);
    chk("rej_n_busy", 32'(bcnt), 0);
    chk("rej_n_out", 32'(o), 0);
    chk("rej_done_one_cycle", 32'(done), 0);
    run(13'd4000, 0, 0, o, lat, bcnt);
    chk("rej_4000_err", 32'(err), 1);
    chk("rej_4000_lat", 32'(lat), 1);
    chk("rej_4000_busy", 32'(bcnt), 0);
    chk("rej_4000_out", 32'(o), 0);

    run(13'd2790, 50, 1, o, lat, bcnt);
    chk("ignore_out", 32'(o), 65);
    chk("ignore_lat", 32'(lat), 236);
    chk("ignore_err_cleared", 32'(err), 0);

    // 48^7 mod 143 = 126; 103 inverts 7 mod 120, so 48^103 mod 143 = 9.
    load(13'd143, 1'b1);
    load(13'd7, 1'b0);
    run(13'd48, 0, 0, o, lat, bcnt);
    chk("n143_d7_out", 32'(o), 126);
    chk("n143_d7_lat", 32'(lat), 210);
    run(13'd2790, 0, 0, o, lat, bcnt);
    chk("n143_reject_err", 32'(err), 1);
    load(13'd103, 1'b0);
    run(13'd48, 0, 0, o, lat, bcnt);
    chk("n143_d103_out", 32'(o), 9);
    chk("n143_d103_lat", 32'(lat), 236);

    run(13'd100, 100, 2, o, lat, bcnt);
    chk("rst_mid_no_done", 32'(lat), 32'hFFFF_FFFF);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_out", 32'(output_data), 0);
    chk("rst_mid_err", 32'(err), 0);
    bcnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done) bcnt++;
    end
    chk("rst_hold_no_done", 32'(bcnt), 0);
    rst_n = 1'b1;
    tick();
    run(13'd2790, 0, 0, o, lat, bcnt);
    chk("post_rst_out", 32'(o), 65);
    chk("post_rst_lat", 32'(lat), 236);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
